// File: rtl/libv_deque_if.sv
// Command type shared by the deque and its users, plus the deque's
// command/response interface. The requester drives the command side
// (master); the deque drives results and status (slave).
package libv_pkg;
    typedef enum logic [1:0] {
        PushFront = 2'b00,
        PopFront  = 2'b01,
        PushBack  = 2'b10,
        PopBack   = 2'b11
    } cmd_t;
endpackage

interface libv_deque_if #(
    parameter int W = 32,
    parameter int N = 4
);
    logic                     in_vld;
    libv_pkg::cmd_t           in_cmd;
    logic [W-1:0]             in_dat;
    logic                     out_vld;
    logic [W-1:0]             out_dat;
    logic                     empty;
    logic                     full;
    logic [$clog2(N+1)-1:0]   cnt;
    logic                     drop;
    logic                     err;

    modport master (
        output in_vld, in_cmd, in_dat,
        input  out_vld, out_dat, empty, full, cnt, drop, err
    );

    modport slave (
        input  in_vld, in_cmd, in_dat,
        output out_vld, out_dat, empty, full, cnt, drop, err
    );
endinterface

// File: rtl/libv_deque.sv
// Double-ended queue on an N-entry ring buffer. One command per cycle;
// pop data, error and drop flags are registered and appear one cycle
// after the command. With OVERWRITE set, a push into a full deque evicts
// the entry at the opposite end instead of being rejected.
module libv_deque #(
    parameter int W         = 32,
    parameter int N         = 4,
    parameter int OVERWRITE = 0
) (
    input  logic        clk,
    input  logic        rst,
    libv_deque_if.slave bus
);
    import libv_pkg::*;

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(N);

    logic [W-1:0]  mem [N];
    logic [IW-1:0] headQ, tailQ, headNxt, tailNxt;
    logic [CW-1:0] cntQ, cntNxt;
    logic          isFull, isEmpty;
    logic          wrEn, rdEn, errNxt, dropNxt;
    logic [IW-1:0] wrIdx, rdIdx;
    logic          outVldQ, errQ, dropQ;
    logic [W-1:0]  outDatQ;

    // Ring indices wrap explicitly so N need not be a power of two.
    function automatic logic [IW-1:0] incIdx(input logic [IW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IW'(1);
    endfunction

    function automatic logic [IW-1:0] decIdx(input logic [IW-1:0] idx);
        return (idx == '0) ? LAST_IDX : idx - IW'(1);
    endfunction

    assign isFull  = (cntQ == FULL_CNT);
    assign isEmpty = (cntQ == '0);

    // Decode the command into index/count updates and one memory access.
    always_comb begin
        headNxt = headQ;
        tailNxt = tailQ;
        cntNxt  = cntQ;
        wrEn    = 1'b0;
        wrIdx   = tailQ;
        rdEn    = 1'b0;
        rdIdx   = headQ;
        errNxt  = 1'b0;
        dropNxt = 1'b0;
        if (bus.in_vld) begin
            unique case (bus.in_cmd)
                PushFront: begin
                    if (!isFull || OVERWRITE != 0) begin
                        headNxt = decIdx(headQ);
                        wrEn    = 1'b1;
                        wrIdx   = decIdx(headQ);
                        if (isFull) begin
                            // Back entry is sacrificed to make room.
                            tailNxt = decIdx(tailQ);
                            dropNxt = 1'b1;
                        end else begin
                            cntNxt = cntQ + CW'(1);
                        end
                    end else begin
                        errNxt = 1'b1;
                    end
                end
                PushBack: begin
                    if (!isFull || OVERWRITE != 0) begin
                        tailNxt = incIdx(tailQ);
                        wrEn    = 1'b1;
                        wrIdx   = tailQ;
                        if (isFull) begin
                            // Front entry is sacrificed to make room.
                            headNxt = incIdx(headQ);
                            dropNxt = 1'b1;
                        end else begin
                            cntNxt = cntQ + CW'(1);
                        end
                    end else begin
                        errNxt = 1'b1;
                    end
                end
                PopFront: begin
                    if (!isEmpty) begin
                        rdEn    = 1'b1;
                        rdIdx   = headQ;
                        headNxt = incIdx(headQ);
                        cntNxt  = cntQ - CW'(1);
                    end else begin
                        errNxt = 1'b1;
                    end
                end
                PopBack: begin
                    if (!isEmpty) begin
                        rdEn    = 1'b1;
                        rdIdx   = decIdx(tailQ);
                        tailNxt = decIdx(tailQ);
                        cntNxt  = cntQ - CW'(1);
                    end else begin
                        errNxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state and registered pop result; reset discards any command.
    always_ff @(posedge clk) begin
        if (rst) begin
            headQ   <= '0;
            tailQ   <= '0;
            cntQ    <= '0;
            outVldQ <= 1'b0;
            errQ    <= 1'b0;
            dropQ   <= 1'b0;
            outDatQ <= '0;
        end else begin
            headQ   <= headNxt;
            tailQ   <= tailNxt;
            cntQ    <= cntNxt;
            outVldQ <= rdEn;
            errQ    <= errNxt;
            dropQ   <= dropNxt;
            if (rdEn) begin
                outDatQ <= mem[rdIdx];
            end
        end
    end

    // Storage is not reset; a write under reset is dropped with its command.
    always_ff @(posedge clk) begin
        if (wrEn && !rst) begin
            mem[wrIdx] <= bus.in_dat;
        end
    end

    assign bus.out_vld = outVldQ;
    assign bus.out_dat = outDatQ;
    assign bus.err     = errQ;
    assign bus.drop    = dropQ;
    assign bus.cnt     = cntQ;
    assign bus.empty   = isEmpty;
    assign bus.full    = isFull;
endmodule
